// File: rtl/eq_gain_ctrl_if.sv
// Purpose : bundles the adjust/commit signals of the equalizer gain controller.
// Latency : n/a (wires only).
// Backpressure: none; all controls are single-cycle pulses, commits are strobes.
//
// Signals:
//   i_band, i_inc, i_dec, i_preset : band adjust controls (driven by master)
//   i_doneR, i_dsp_done            : commit window close/open pulses (master)
//   o_gain, o_set_gain             : registered gain write strobe (slave)
//   o_dirty, o_busy                : pending-commit mask and busy flag (slave)
//   i_rd_band, o_rd_gain           : gain readback, present only with
//                                    EQ_GAIN_READBACK_EN defined
interface eq_gain_ctrl_if;
    logic [2:0]  i_band;
    logic        i_inc;
    logic        i_dec;
    logic        i_preset;
    logic        i_doneR;
    logic        i_dsp_done;
    logic [15:0] o_gain;
    logic [2:0]  o_set_gain;
    logic [5:0]  o_dirty;
    logic        o_busy;
`ifdef EQ_GAIN_READBACK_EN
    logic [2:0]  i_rd_band;
    logic [15:0] o_rd_gain;

    modport master (
        output i_band, i_inc, i_dec, i_preset, i_doneR, i_dsp_done, i_rd_band,
        input  o_gain, o_set_gain, o_dirty, o_busy, o_rd_gain
    );
    modport slave (
        input  i_band, i_inc, i_dec, i_preset, i_doneR, i_dsp_done, i_rd_band,
        output o_gain, o_set_gain, o_dirty, o_busy, o_rd_gain
    );
`else
    modport master (
        output i_band, i_inc, i_dec, i_preset, i_doneR, i_dsp_done,
        input  o_gain, o_set_gain, o_dirty, o_busy
    );
    modport slave (
        input  i_band, i_inc, i_dec, i_preset, i_doneR, i_dsp_done,
        output o_gain, o_set_gain, o_dirty, o_busy
    );
`endif
endinterface

// File: rtl/eq_gain_ctrl.sv
// Purpose : six-band equalizer gain store with saturating step adjust and
//           windowed, one-band-per-cycle commit of changed gains.
// Latency : one cycle from an eligible open-window cycle to o_set_gain.
// Backpressure: i_doneR closes the commit window; pending bands wait in o_dirty.
//
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-high reset
//   bus    : eq_gain_ctrl_if.slave (adjust inputs, window pulses, commit outputs)
// Optional feature: define EQ_GAIN_READBACK_EN to add i_rd_band/o_rd_gain
// (registered readback of any band's current gain).
module eq_gain_ctrl #(
    parameter logic [15:0] GAIN_UNITY = 16'h1000,
    parameter logic [15:0] GAIN_STEP  = 16'h0200,
    parameter logic [15:0] GAIN_MIN   = 16'h0200,
    parameter logic [15:0] GAIN_MAX   = 16'h4000
) (
    input  logic          i_clk,
    input  logic          i_rst,
    eq_gain_ctrl_if.slave bus
);

    localparam logic [0:0] S_OPEN   = 1'b0;
    localparam logic [0:0] S_CLOSED = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [15:0] gain_q [6];
    logic [15:0] gain_d [6];
    logic [5:0]  dirty_q, dirty_d;
    logic [2:0]  set_gain_q, set_gain_d;
    logic [15:0] out_gain_q, out_gain_d;

    logic        band_ok;
    logic        adj_vld;
    logic        commit_vld;
    logic [5:0]  commit_mask;
    logic [2:0]  commit_band;
    logic [15:0] commit_gain;

    // 17-bit sum so a step past 16'hFFFF cannot wrap below GAIN_MAX.
    function automatic logic [15:0] step_up(input logic [15:0] g);
        logic [16:0] sum;
        sum = {1'b0, g} + {1'b0, GAIN_STEP};
        if (sum > {1'b0, GAIN_MAX}) begin
            return GAIN_MAX;
        end
        return sum[15:0];
    endfunction

    // Compare before subtracting so the result never wraps.
    function automatic logic [15:0] step_down(input logic [15:0] g);
        logic [16:0] floor_plus_step;
        floor_plus_step = {1'b0, GAIN_MIN} + {1'b0, GAIN_STEP};
        if ({1'b0, g} < floor_plus_step) begin
            return GAIN_MIN;
        end
        return g - GAIN_STEP;
    endfunction

    // Window FSM: a sample start closes it, completion reopens it; the
    // close request wins so no commit lands while the datapath samples.
    always_comb begin
        state_d = state_q;
        if (bus.i_doneR) begin
            state_d = S_CLOSED;
        end else if (bus.i_dsp_done) begin
            state_d = S_OPEN;
        end
    end

    // Lowest pending band wins: scan downwards so the last hit is the lowest.
    always_comb begin
        commit_vld  = (state_q == S_OPEN) && !bus.i_doneR && (dirty_q != 6'h00);
        commit_mask = '0;
        commit_band = '0;
        commit_gain = '0;
        for (int k = 5; k >= 0; k--) begin
            if (dirty_q[k]) begin
                commit_mask    = '0;
                commit_mask[k] = 1'b1;
                commit_band    = 3'(k + 1);
                commit_gain    = gain_q[k];
            end
        end
    end

    // Gain and dirty update. The commit clears its bit before the adjust sets
    // one, so an adjust hitting the band being committed keeps it pending and
    // the newer value goes out on a later cycle.
    always_comb begin
        band_ok = (bus.i_band >= 3'd1) && (bus.i_band <= 3'd6);
        adj_vld = band_ok && (bus.i_inc ^ bus.i_dec);

        dirty_d = dirty_q;
        if (commit_vld) begin
            dirty_d = dirty_q & ~commit_mask;
        end

        for (int b = 0; b < 6; b++) begin
            gain_d[b] = gain_q[b];
            if (bus.i_preset) begin
                gain_d[b] = GAIN_UNITY;
            end else if (adj_vld && (bus.i_band == 3'(b + 1))) begin
                gain_d[b]  = bus.i_inc ? step_up(gain_q[b]) : step_down(gain_q[b]);
                dirty_d[b] = 1'b1;
            end
        end

        if (bus.i_preset) begin
            dirty_d = 6'h3F;
        end

        set_gain_d = commit_vld ? commit_band : 3'd0;
        out_gain_d = commit_vld ? commit_gain : out_gain_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_OPEN;
            dirty_q    <= 6'h3F;
            set_gain_q <= 3'd0;
            out_gain_q <= 16'h0000;
            for (int b = 0; b < 6; b++) begin
                gain_q[b] <= GAIN_UNITY;
            end
        end else begin
            state_q    <= state_d;
            dirty_q    <= dirty_d;
            set_gain_q <= set_gain_d;
            out_gain_q <= out_gain_d;
            for (int b = 0; b < 6; b++) begin
                gain_q[b] <= gain_d[b];
            end
        end
    end

    assign bus.o_gain     = out_gain_q;
    assign bus.o_set_gain = set_gain_q;
    assign bus.o_dirty    = dirty_q;
    assign bus.o_busy     = (dirty_q != 6'h00);

`ifdef EQ_GAIN_READBACK_EN
    logic [15:0] rd_gain_q, rd_gain_d;

    // Bands 0 and 7 do not exist and read as zero.
    always_comb begin
        rd_gain_d = '0;
        for (int b = 0; b < 6; b++) begin
            if (bus.i_rd_band == 3'(b + 1)) begin
                rd_gain_d = gain_q[b];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_gain_q <= 16'h0000;
        end else begin
            rd_gain_q <= rd_gain_d;
        end
    end

    assign bus.o_rd_gain = rd_gain_q;
`endif

endmodule

// File: tb/tb_eq_gain_ctrl.sv
// Purpose : directed bench for eq_gain_ctrl; expected commits (band, gain and
//           the cycle they must appear in) are queued by the stimulus and
//           popped by an independent monitor on the falling edge.
module tb_eq_gain_ctrl;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    typedef struct {
        logic [2:0]  band;
        logic [15:0] gain;
        int          at;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    eq_gain_ctrl_if bus();

    eq_gain_ctrl dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    // Edge counter: after edge N (and #1) cyc reads N.
    always @(posedge i_clk) cyc <= cyc + 1;

    // Commit monitor: every strobe must match the head of the queue exactly,
    // including the cycle it was predicted for.
    always @(negedge i_clk) begin
        if (bus.o_set_gain != 3'd0) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_commit: got band %0d gain %h at cycle %0d, required no commit",
                         bus.o_set_gain, bus.o_gain, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                if (bus.o_set_gain !== mon_e.band || bus.o_gain !== mon_e.gain || cyc != mon_e.at) begin
                    n_fail++;
                    $display("FAIL commit: got band %0d gain %h at cycle %0d, required band %0d gain %h at cycle %0d",
                             bus.o_set_gain, bus.o_gain, cyc, mon_e.band, mon_e.gain, mon_e.at);
                end
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic void push(input int band, input logic [15:0] gain, input int at);
        exp_t e;
        e.band = 3'(band);
        e.gain = gain;
        e.at   = at;
        sb_q.push_back(e);
    endfunction

    initial begin
        bus.i_band     = 3'd0;
        bus.i_inc      = 1'b0;
        bus.i_dec      = 1'b0;
        bus.i_preset   = 1'b0;
        bus.i_doneR    = 1'b0;
        bus.i_dsp_done = 1'b0;
`ifdef EQ_GAIN_READBACK_EN
        bus.i_rd_band  = 3'd0;
`endif
        i_rst = 1'b1;
        tick();
        tick();

        // Reset state.
        chk("rst_set_gain", 32'(bus.o_set_gain), 32'd0);
        chk("rst_gain",     32'(bus.o_gain),     32'h0000);
        chk("rst_dirty",    32'(bus.o_dirty),    32'h3F);
        chk("rst_busy",     32'(bus.o_busy),     32'd1);

        // Release: bands 1..6 commit unity on consecutive cycles.
        i_rst = 1'b0;
        for (int k = 1; k <= 6; k++) push(k, 16'h1000, cyc + k);
        repeat (7) tick();
        chk("drain_dirty",    32'(bus.o_dirty),    32'h00);
        chk("drain_busy",     32'(bus.o_busy),     32'd0);
        chk("drain_set_gain", 32'(bus.o_set_gain), 32'd0);

        // Band 3 stepped up 25 times in a closed window: 23 steps reach 3E00,
        // the 24th lands on 4000 and the 25th saturates. One commit of 4000.
        bus.i_doneR = 1'b1;
        tick();
        bus.i_doneR = 1'b0;
        bus.i_band  = 3'd3;
        bus.i_inc   = 1'b1;
        repeat (25) tick();
        bus.i_inc   = 1'b0;
        chk("sat_closed_dirty", 32'(bus.o_dirty), 32'h04);
        bus.i_dsp_done = 1'b1;
        push(3, 16'h4000, cyc + 2);
        tick();
        bus.i_dsp_done = 1'b0;
        repeat (3) tick();
        chk("sat_dirty", 32'(bus.o_dirty), 32'h00);

        // Preset with a same-cycle inc on band 2: no step applied, full mask.
        // Window closes after the second commit; bands 3..6 wait.
        bus.i_preset = 1'b1;
        bus.i_inc    = 1'b1;
        bus.i_band   = 3'd2;
        push(1, 16'h1000, cyc + 2);
        push(2, 16'h1000, cyc + 3);
        tick();
        bus.i_preset = 1'b0;
        bus.i_inc    = 1'b0;
        chk("preset_dirty", 32'(bus.o_dirty), 32'h3F);
        tick();
        tick();
        bus.i_doneR = 1'b1;
        tick();
        bus.i_doneR = 1'b0;
        chk("close_set_gain", 32'(bus.o_set_gain), 32'd0);
        chk("close_dirty",    32'(bus.o_dirty),    32'h3C);
        repeat (4) tick();
        chk("closed_hold_dirty", 32'(bus.o_dirty), 32'h3C);
        chk("closed_hold_busy",  32'(bus.o_busy),  32'd1);
        bus.i_dsp_done = 1'b1;
        for (int k = 3; k <= 6; k++) push(k, 16'h1000, cyc + k - 1);
        tick();
        bus.i_dsp_done = 1'b0;
        repeat (6) tick();
        chk("reopen_dirty", 32'(bus.o_dirty), 32'h00);

        // Ignored adjusts: inc+dec together, band 7, band 0.
        bus.i_band = 3'd5;
        bus.i_inc  = 1'b1;
        bus.i_dec  = 1'b1;
        tick();
        bus.i_inc  = 1'b0;
        bus.i_dec  = 1'b0;
        chk("incdec_dirty", 32'(bus.o_dirty), 32'h00);
        bus.i_band = 3'd7;
        bus.i_inc  = 1'b1;
        tick();
        bus.i_inc  = 1'b0;
        chk("band7_dirty", 32'(bus.o_dirty), 32'h00);
        bus.i_band = 3'd0;
        bus.i_dec  = 1'b1;
        tick();
        bus.i_dec  = 1'b0;
        chk("band0_dirty", 32'(bus.o_dirty), 32'h00);
        // A real inc on band 5 shows the gain was still unity.
        bus.i_band = 3'd5;
        bus.i_inc  = 1'b1;
        push(5, 16'h1200, cyc + 2);
        tick();
        bus.i_inc  = 1'b0;
        chk("inc5_dirty", 32'(bus.o_dirty), 32'h10);
        repeat (3) tick();

        // Band 4 stepped down 10 times: floors at 0200 after 7, no wrap.
        bus.i_doneR = 1'b1;
        tick();
        bus.i_doneR = 1'b0;
        bus.i_band  = 3'd4;
        bus.i_dec   = 1'b1;
        repeat (10) tick();
        bus.i_dec   = 1'b0;
        chk("floor_closed_dirty", 32'(bus.o_dirty), 32'h08);
        bus.i_dsp_done = 1'b1;
        push(4, 16'h0200, cyc + 2);
        tick();
        bus.i_dsp_done = 1'b0;
        repeat (3) tick();

        // Adjust on the band being committed: it commits again with the new value.
        bus.i_band = 3'd1;
        bus.i_inc  = 1'b1;
        push(1, 16'h1200, cyc + 2);
        push(1, 16'h1400, cyc + 3);
        tick();
        tick();
        bus.i_inc  = 1'b0;
        repeat (3) tick();
        chk("recommit_dirty", 32'(bus.o_dirty), 32'h00);

        // Reset restores modified gains (band1=1400, band4=0200, band5=1200),
        // and a reset mid-drain restarts the full drain.
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        for (int k = 1; k <= 3; k++) push(k, 16'h1000, cyc + k);
        repeat (3) tick();
        i_rst = 1'b1;
        tick();
        chk("midrst_set_gain", 32'(bus.o_set_gain), 32'd0);
        chk("midrst_gain",     32'(bus.o_gain),     32'h0000);
        chk("midrst_dirty",    32'(bus.o_dirty),    32'h3F);
        i_rst = 1'b0;
        for (int k = 1; k <= 6; k++) push(k, 16'h1000, cyc + k);
        repeat (7) tick();
        chk("final_dirty", 32'(bus.o_dirty), 32'h00);
        chk("final_busy",  32'(bus.o_busy),  32'd0);

`ifdef EQ_GAIN_READBACK_EN
        // One decrement from unity on band 4, then read it back.
        bus.i_band = 3'd4;
        bus.i_dec  = 1'b1;
        push(4, 16'h0E00, cyc + 2);
        tick();
        bus.i_dec  = 1'b0;
        bus.i_rd_band = 3'd4;
        tick();
        chk("rd_band4", 32'(bus.o_rd_gain), 32'h0E00);
        bus.i_rd_band = 3'd7;
        tick();
        chk("rd_band7", 32'(bus.o_rd_gain), 32'h0000);
        bus.i_rd_band = 3'd0;
        repeat (3) tick();
`endif

        repeat (3) tick();
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eq_gain_ctrl.md
EQ_GAIN_CTRL -- requirements
Module: eq_gain_ctrl

Interface
REQ-001 Parameter GAIN_UNITY, default 16'h1000, meaning unity gain code loaded by reset and preset.
REQ-002 Parameter GAIN_STEP, default 16'h0200, meaning increment/decrement per adjust pulse.
REQ-003 Parameter GAIN_MIN, default 16'h0200, meaning lower saturation bound; parameter GAIN_MAX, default 16'h4000, meaning upper saturation bound.
REQ-004 i_clk  in  1  the single clock; all logic is on its rising edge.
REQ-005 i_rst  in  1  reset, synchronous and active-high.
REQ-006 i_band  in  3  band select for adjust, 1..6; values 0 and 7 are ignored.
REQ-007 i_inc / i_dec  in  1 each  single-cycle adjust pulses for i_band.
REQ-008 i_preset  in  1  single-cycle pulse: all six bands return to GAIN_UNITY.
REQ-009 i_doneR  in  1  sample-start pulse, shared with the equalizer datapath; closes the commit window.
REQ-010 i_dsp_done  in  1  equalizer completion pulse; opens the commit window.
REQ-011 o_gain  out  16  registered gain value for the band in o_set_gain.
REQ-012 o_set_gain  out  3  registered band write strobe, 1..6; 0 means no write.
REQ-013 o_dirty  out  6  pending-commit mask, bit k-1 for band k.
REQ-014 o_busy  out  1  high while o_dirty is nonzero.

Function
REQ-015 The block SHALL hold six 16-bit gain registers, one per band.
REQ-016 On i_inc with valid i_band and without i_dec, the band gain SHALL become min(gain+GAIN_STEP, GAIN_MAX) using 17-bit intermediates, and its dirty bit SHALL be set.
REQ-017 On i_dec with valid i_band and without i_inc, the band gain SHALL become max(gain-GAIN_STEP, GAIN_MIN) with no underflow wrap, and its dirty bit SHALL be set.
REQ-018 i_inc and i_dec together, or an invalid i_band, SHALL cause no change and no dirty bit.
REQ-019 The dirty bit SHALL be set even when saturation leaves the value unchanged.
REQ-020 i_preset SHALL take priority over a same-cycle adjust: all gains become GAIN_UNITY and o_dirty becomes 6'h3F.
REQ-021 The FSM SHALL have the states S_OPEN (window open, may commit) and S_CLOSED (datapath computing, no commits).
REQ-022 S_OPEN -> S_CLOSED when i_doneR is 1; S_CLOSED -> S_OPEN when i_dsp_done is 1; i_doneR SHALL take priority if both are 1.
REQ-023 In S_OPEN with i_doneR=0 and o_dirty nonzero, the block SHALL, on each cycle, select the lowest set dirty bit k, register o_set_gain=k+1 and o_gain=gain[k], and clear bit k.
REQ-024 In all other cycles, o_set_gain SHALL register 0; o_gain SHALL hold its last value.
REQ-025 o_set_gain SHALL be 0 in the cycle after any cycle in which i_doneR=1, and remaining dirty bits SHALL stay pending until the next window.
REQ-026 An adjust that hits the band being committed in the same cycle SHALL leave its dirty bit set, so that the new value is committed later.
REQ-027 Commit latency SHALL be one cycle from the eligible S_OPEN cycle to the o_set_gain strobe; a full mask SHALL drain in 6 consecutive cycles.

Reset
REQ-028 When i_rst=1: state becomes S_OPEN, all gains become GAIN_UNITY, o_dirty becomes 6'h3F, o_set_gain becomes 0, o_gain becomes 0, and o_busy becomes 1.
REQ-029 A reset mid-drain SHALL discard progress; all six bands SHALL be recommitted after reset.

Configuration
REQ-030 With macro EQ_GAIN_READBACK_EN defined, the block SHALL add input i_rd_band (3 bits) and output o_rd_gain (16 bits).
REQ-031 o_rd_gain SHALL be registered, equal to gain[i_rd_band-1] one cycle later, and 0 for i_rd_band of 0 or 7; it SHALL reset to 0.
REQ-032 Without EQ_GAIN_READBACK_EN, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Release reset with no i_doneR -> o_set_gain = 1,2,3,4,5,6 on consecutive cycles, each with o_gain=16'h1000, then 0; o_dirty=0 and o_busy=0.
REQ-034 Band 3 at 16'h3F00, pulse i_inc twice -> gain 16'h4000 (saturated), one commit of o_set_gain=3 with o_gain=16'h4000.
REQ-035 Full mask, pulse i_doneR after the second commit -> o_set_gain=0 from the next cycle, o_dirty=6'h3C held; after an i_dsp_done pulse, bands 3..6 commit.
REQ-036 i_preset together with i_inc on band 2 -> all gains 16'h1000, o_dirty=6'h3F, and no step applied.
REQ-037 i_inc and i_dec together on band 5 -> no gain change and o_dirty unchanged; i_band=7 with i_inc -> no effect.
REQ-038 With EQ_GAIN_READBACK_EN defined, i_rd_band=4 after one decrement from unity -> o_rd_gain=16'h0E00 one cycle later.
